// File: rtl/a2d_spi_slv.sv
// SPI slave front end for an A2D: receives 16-bit commands, returns the previous command's conversion result.
// Latency: pin edges are acted on 3 clk after they occur; the result is captured 1 clk after a valid frame ends.
// Backpressure: none; the SPI master owns the timing, and frames with a bit count other than 16 raise frm_err.
module a2d_spi_slv #(
    parameter logic [11:0] RESET_RESULT = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] chan_data,
    output logic [2:0]  chan_sel,
    output logic [15:0] cmd_reg,
    output logic        cmd_rdy,
    output logic        frm_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CONV  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // [0],[1] synchronize; [2] is the history stage used for edge detection
    logic [2:0]  ss_sync;
    logic [2:0]  sclk_sync;
    logic [2:0]  mosi_sync;

    logic        ss_fall;
    logic        ss_rise;
    logic        sclk_fall;
    logic        sclk_rise;
    logic        mosi_s;

    logic [15:0] tx_shift;
    logic [15:0] rx_shift;
    logic [4:0]  bit_cnt;
    logic        first_fall;
    logic [11:0] result;

    logic        ld_tx;
    logic        ld_bypass;
    logic        do_rx;
    logic        do_tx;
    logic        ld_cmd;
    logic        set_err;
    logic        ld_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 3'b111;
        end else begin
            ss_sync   <= {ss_sync[1:0], SS_n};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[1:0], MOSI};
        end
    end

    assign ss_fall   =  ss_sync[2]   & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2]   &  ss_sync[1];
    assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
    assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
    // History stage keeps the MOSI sample no younger than the SCLK rise it pairs with
    assign mosi_s    =  mosi_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_tx     = 1'b0;
        ld_bypass = 1'b0;
        do_rx     = 1'b0;
        do_tx     = 1'b0;
        ld_cmd    = 1'b0;
        set_err   = 1'b0;
        ld_result = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt = SHIFT;
                    ld_tx     = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    if (bit_cnt == 5'd16) begin
                        ld_cmd    = 1'b1;
                        state_nxt = CONV;
                    end else begin
                        set_err   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    do_rx = sclk_rise;
                    do_tx = sclk_fall;
                end
            end
            CONV: begin
                // chan_sel already reflects the new cmd_reg here
                ld_result = 1'b1;
                if (ss_fall) begin
                    state_nxt = SHIFT;
                    ld_tx     = 1'b1;
                    ld_bypass = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift   <= 16'h0000;
            rx_shift   <= 16'h0000;
            bit_cnt    <= 5'd0;
            first_fall <= 1'b0;
            cmd_reg    <= 16'h0000;
            result     <= RESET_RESULT;
            cmd_rdy    <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            cmd_rdy <= ld_cmd;
            frm_err <= set_err;
            if (ld_tx) begin
                tx_shift   <= {4'h0, (ld_bypass ? chan_data : result)};
                rx_shift   <= 16'h0000;
                bit_cnt    <= 5'd0;
                first_fall <= 1'b1;
            end
            if (do_rx) begin
                rx_shift <= {rx_shift[14:0], mosi_s};
                if (bit_cnt != 5'd31) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            // The first SCLK fall only opens the frame; bit 15 is already on MISO
            if (do_tx) begin
                if (first_fall) begin
                    first_fall <= 1'b0;
                end else begin
                    tx_shift <= {tx_shift[14:0], 1'b0};
                end
            end
            if (ld_cmd) begin
                cmd_reg <= rx_shift;
            end
            if (ld_result) begin
                result <= chan_data;
            end
        end
    end

    assign MISO     = (state == SHIFT) ? tx_shift[15] : 1'b1;
    assign chan_sel = cmd_reg[13:11];

endmodule

// File: doc/a2d_spi_slv.md
A2D_SPI_SLV -- requirements
Module: a2d_spi_slv

Interface
REQ-001 SHALL have parameter RESET_RESULT, default 12'h000, meaning the conversion result value held after reset.
REQ-002 SHALL have port clk, input, 1, system clock (50 MHz).
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port SS_n, input, 1, active-low slave select from the SPI master.
REQ-005 SHALL have port SCLK, input, 1, SPI clock from the master; idles high.
REQ-006 SHALL have port MOSI, input, 1, serial command from the master; MSB first.
REQ-007 SHALL have port MISO, output, 1, serial response to the master; MSB first.
REQ-008 SHALL have port chan_data, input, 12, analog value for the channel on chan_sel.
REQ-009 SHALL have port chan_sel, output, 3, channel taken from the last valid command, cmd_reg[13:11].
REQ-010 SHALL have port cmd_reg, output, 16, last valid 16-bit command received.
REQ-011 SHALL have port cmd_rdy, output, 1, one-clk pulse when a valid command is latched.
REQ-012 SHALL have port frm_err, output, 1, one-clk pulse when a frame ends with a bit count other than 16.

Function
REQ-013 SHALL pass SS_n, SCLK and MOSI through two synchronizing flops plus one history flop, then detect edges on the synchronized signals; rise and fall detection lags the pins by 3 clk.
REQ-014 SHALL implement three states, IDLE, SHIFT and CONV, with IDLE as the reset state.
REQ-015 IDLE: on a synchronized SS_n fall, SHALL go to SHIFT, load tx_shift = {4'h0, result}, clear the 5-bit bit counter, and set the first-fall flag.
REQ-016 SHIFT: on each synchronized SCLK rise, SHALL shift the synchronized MOSI into the LSB of rx_shift and increment the bit counter, saturating at 31.
REQ-017 SHIFT: on each synchronized SCLK fall, SHALL left-shift tx_shift, except that the first fall of a frame only clears the first-fall flag.
REQ-018 MISO SHALL equal tx_shift[15] while in SHIFT, and SHALL be 1'b1 otherwise.
REQ-019 SHIFT, on SS_n rise with bit counter == 16: SHALL load cmd_reg <= rx_shift, pulse cmd_rdy for one clk, and go to CONV.
REQ-020 SHIFT, on SS_n rise with bit counter != 16: SHALL leave cmd_reg and result unchanged, pulse frm_err for one clk, and go to IDLE.
REQ-021 CONV (exactly 1 clk): SHALL load result <= chan_data, sampled while chan_sel reflects the new cmd_reg, then go to IDLE.
REQ-022 If an SS_n fall is detected during the CONV cycle, SHALL enter SHIFT next with tx_shift loaded from chan_data (bypass), so the new result is returned.
REQ-023 Each frame SHALL therefore return the conversion for the command of the previous valid frame; the first frame after reset returns RESET_RESULT.
REQ-024 SCLK edges while SS_n is high SHALL be ignored.
REQ-025 cmd_reg bits other than [13:11] SHALL be stored but have no functional effect.
REQ-026 cmd_rdy and frm_err SHALL never assert in the same cycle.

Reset
REQ-027 Asserting rst_n low SHALL asynchronously set: state = IDLE, MISO = 1, cmd_reg = 16'h0000, chan_sel = 3'b000, result = RESET_RESULT, cmd_rdy = 0, frm_err = 0, all shift registers and counters = 0, and all synchronizer flops = 1.
REQ-028 A reset in the middle of a frame SHALL discard that frame; the next SS_n fall after release begins a clean frame.

Verification
REQ-029 First frame after reset, cmd 16'h2000 (channel 4), with chan_data = 12'hABC presented when chan_sel == 4 -> MISO returns 16'h0000, cmd_reg = 16'h2000, chan_sel = 3'b100, one cmd_rdy pulse.
REQ-030 Second frame, cmd 16'h2800 -> MISO returns 16'h0ABC, chan_sel changes to 3'b101.
REQ-031 SS_n rises after 9 SCLK rises -> one frm_err pulse, no cmd_rdy, cmd_reg and the next MISO response unchanged.
REQ-032 SCLK toggled 8 times while SS_n is high, followed by a valid frame -> bit count is exactly 16 and the response is unaffected.
REQ-033 rst_n pulsed low after 7 bits of a frame -> MISO = 1, result = RESET_RESULT, and a following full frame returns 16'h0000 and latches correctly.
REQ-034 Back-to-back frames driven by the existing SPI master at SCLK = clk/32, with the minimum SS_n high gap -> every response matches the previous command's chan_data, and there is no frm_err.
